// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin burst arbiter between two valid/ready sources
// feeding one registered output channel; owns the 2-1 mux select.
module mux_rr_arbiter #(
  parameter int WIDTH = 8,
  parameter int BURST = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             sel
);

  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST - 1);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_A,
    SERVE_B
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             r_last;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;

  logic             w_idle;
  logic             w_can_load;
  logic             w_owner;
  logic             w_own_valid;
  logic [WIDTH-1:0] w_own_data;
  logic             w_a_ready;
  logic             w_b_ready;
  logic             w_accept;

  // r_last=1 means B took the latest beat, so A wins the next tie
  always_comb begin
    w_idle     = (r_state == IDLE);
    w_can_load = !r_out_valid || out_ready;
    w_owner    = 1'b0;
    case (r_state)
      IDLE:    w_owner = !(a_valid && (!b_valid || r_last)) && b_valid;
      SERVE_A: w_owner = 1'b0;
      SERVE_B: w_owner = 1'b1;
      default: w_owner = 1'b0;
    endcase
    w_own_valid = w_owner ? b_valid : a_valid;
    w_own_data  = w_owner ? b_data : a_data;
  end

  assign w_a_ready = w_can_load && !w_owner && (a_valid || !w_idle);
  assign w_b_ready = w_can_load && w_owner && (b_valid || !w_idle);
  assign w_accept  = w_own_valid && (w_owner ? w_b_ready : w_a_ready);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (w_accept) begin
      if (r_cnt == LAST_BEAT) begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end else begin
        w_state_nxt = w_owner ? SERVE_B : SERVE_A;
        w_cnt_nxt   = r_cnt + 1'b1;
      end
    end else if (!w_idle && !w_own_valid) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_last      <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_own_data;
        r_last      <= w_owner;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign a_ready   = w_a_ready;
  assign b_ready   = w_b_ready;
  assign sel       = w_owner;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: three arbiters (BURST 1, 2, 4) on shared stimulus,
// checked against a grant/beat-count reference model.
module tb_mux_rr_arbiter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         av = 1'b0;
  logic         bv = 1'b0;
  logic         ordy = 1'b0;
  logic [W-1:0] ad = '0;
  logic [W-1:0] bd = '0;

  logic [2:0]   ar, br, ov, sl;
  logic [W-1:0] od [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mux_rr_arbiter #(
      .WIDTH(W),
      .BURST(g == 0 ? 1 : (g == 1 ? 2 : 4))
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .a_valid  (av),
      .a_data   (ad),
      .a_ready  (ar[g]),
      .b_valid  (bv),
      .b_data   (bd),
      .b_ready  (br[g]),
      .out_valid(ov[g]),
      .out_data (od[g]),
      .out_ready(ordy),
      .sel      (sl[g])
    );
  end

  int n_vec = 0;
  int n_err = 0;

  // model: grant holder (-1 none), beats taken in grant, last winner
  int           bl [3] = '{1, 2, 4};
  int           m_own [3];
  int           m_cnt [3];
  int           m_last [3];
  bit           m_ov [3];
  logic [W-1:0] m_od [3];

  int           e_own [3];
  bit           e_idle [3];
  logic [2:0]   e_ar, e_br, e_sl, e_ov;
  logic [W-1:0] e_od [3];

  function automatic void m_reset();
    for (int i = 0; i < 3; i++) begin
      m_own[i]  = -1;
      m_cnt[i]  = 0;
      m_last[i] = 1;
      m_ov[i]   = 1'b0;
      m_od[i]   = '0;
    end
  endfunction

  function automatic void m_eval();
    for (int i = 0; i < 3; i++) begin
      bit can;
      bit idle;
      int own;
      can  = !m_ov[i] || ordy;
      idle = (m_own[i] < 0);
      if (!idle) own = m_own[i];
      else if (av && (!bv || m_last[i] == 1)) own = 0;
      else if (bv) own = 1;
      else own = 0;
      e_own[i]  = own;
      e_idle[i] = idle;
      e_ar[i]   = can && own == 0 && (av || !idle);
      e_br[i]   = can && own == 1 && (bv || !idle);
      e_sl[i]   = (own == 1);
      e_ov[i]   = m_ov[i];
      e_od[i]   = m_od[i];
    end
  endfunction

  function automatic void m_adv();
    for (int i = 0; i < 3; i++) begin
      bit acc;
      bit ownv;
      ownv = (e_own[i] == 0) ? av : bv;
      acc  = (e_own[i] == 0) ? (av && e_ar[i]) : (bv && e_br[i]);
      if (acc) begin
        m_od[i]   = (e_own[i] == 0) ? ad : bd;
        m_ov[i]   = 1'b1;
        m_last[i] = e_own[i];
        m_cnt[i]++;
        if (m_cnt[i] == bl[i]) begin
          m_own[i] = -1;
          m_cnt[i] = 0;
        end else begin
          m_own[i] = e_own[i];
        end
      end else begin
        if (ordy) m_ov[i] = 1'b0;
        if (!e_idle[i] && !ownv) begin
          m_own[i] = -1;
          m_cnt[i] = 0;
        end
      end
    end
  endfunction

  task automatic drive(input logic a_v, input logic [W-1:0] a_d,
                       input logic b_v, input logic [W-1:0] b_d,
                       input logic o_r);
    av   = a_v;
    ad   = a_d;
    bv   = b_v;
    bd   = b_d;
    ordy = o_r;
    #1;
    m_eval();
  endtask

  task automatic tick();
    m_adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    av    = 1'b0;
    bv    = 1'b0;
    ordy  = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    av    = 1'b0;
    bv    = 1'b0;
    ordy  = 1'b0;
    m_reset();
    #3;
    n_vec++;
    if ({ov, ar, br, sl} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_ctl: ov=%b ar=%b br=%b sel=%b want all 0",
               ov, ar, br, sl);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (ov[i] !== 1'b0 || ar[i] !== 1'b0 || od[i] !== '0) begin
        n_err++;
        $display("FAIL reset_idle[%0d]: ov=%b ar=%b od=%h want 0 0 00",
                 i, ov[i], ar[i], od[i]);
      end
    end
    tick();
  endtask

  task automatic test_a_only();
    logic [W-1:0] d;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      d = W'(8'h11 * (k + 1));
      drive(k < 3, d, 1'b0, '0, 1'b1);
      if (k > 0) begin
        for (int i = 0; i < 3; i++) begin
          n_vec++;
          if (ov[i] !== 1'b1 || od[i] !== W'(8'h11 * k)) begin
            n_err++;
            $display("FAIL a_only_out[%0d] k=%0d: ov=%b od=%h want 1 %h",
                     i, k, ov[i], od[i], W'(8'h11 * k));
          end
        end
      end
      if (k < 3) begin
        n_vec++;
        if (ar !== 3'b111 || sl !== 3'b000) begin
          n_err++;
          $display("FAIL a_only_rdy k=%0d: ar=%b sel=%b want 111 000",
                   k, ar, sl);
        end
      end
      tick();
    end
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    n_vec++;
    if (ov !== 3'b000) begin
      n_err++;
      $display("FAIL a_only_drain: ov=%b want 000", ov);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [5:0]   pat;
    logic [W-1:0] prev;
    pat = 6'b001100;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, W'(8'hA0 + k), 1'b1, W'(8'hB0 + k), 1'b1);
      n_vec++;
      if (br[1] !== pat[k] || ar[1] !== !pat[k]) begin
        n_err++;
        $display("FAIL rr_order k=%0d: ar=%b br=%b want %b %b",
                 k, ar[1], br[1], !pat[k], pat[k]);
      end
      if (k > 0) begin
        prev = pat[k-1] ? W'(8'hB0 + k - 1) : W'(8'hA0 + k - 1);
        n_vec++;
        if (ov[1] !== 1'b1 || od[1] !== prev) begin
          n_err++;
          $display("FAIL rr_out k=%0d: ov=%b od=%h want 1 %h",
                   k, ov[1], od[1], prev);
        end
      end
      n_vec++;
      if ({ar, br, sl, ov} !== {e_ar, e_br, e_sl, e_ov}) begin
        n_err++;
        $display("FAIL rr_model k=%0d: ar=%b br=%b sel=%b ov=%b want %b %b %b %b",
                 k, ar, br, sl, ov, e_ar, e_br, e_sl, e_ov);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int k = 0; k < 7; k++) begin
      if (k == 0) drive(1'b1, 8'h5A, 1'b0, '0, 1'b0);
      else if (k < 4) drive(1'b1, 8'h6B, 1'b0, '0, 1'b0);
      else if (k == 4) drive(1'b1, 8'h6B, 1'b0, '0, 1'b1);
      else drive(1'b0, '0, 1'b0, '0, 1'b1);
      for (int i = 0; i < 3; i++) begin
        n_vec++;
        if ((k == 0 && ar[i] !== 1'b1) ||
            (k >= 1 && k <= 3 && (ar[i] !== 1'b0 || ov[i] !== 1'b1 ||
                                  od[i] !== 8'h5A)) ||
            (k == 4 && (ar[i] !== 1'b1 || od[i] !== 8'h5A)) ||
            (k == 5 && (ov[i] !== 1'b1 || od[i] !== 8'h6B)) ||
            (k == 6 && ov[i] !== 1'b0)) begin
          n_err++;
          $display("FAIL bp[%0d] k=%0d: ar=%b ov=%b od=%h",
                   i, k, ar[i], ov[i], od[i]);
        end
      end
      tick();
    end
  endtask

  task automatic test_release();
    do_reset();
    drive(1'b1, 8'hC1, 1'b1, 8'hD1, 1'b1);
    n_vec++;
    if (ar[2] !== 1'b1 || sl[2] !== 1'b0) begin
      n_err++;
      $display("FAIL rel_first: ar=%b sel=%b want 1 0", ar[2], sl[2]);
    end
    tick();
    drive(1'b0, '0, 1'b1, 8'hD1, 1'b1);
    n_vec++;
    if (br[2] !== 1'b0 || sl[2] !== 1'b0 || od[2] !== 8'hC1) begin
      n_err++;
      $display("FAIL rel_drop: br=%b sel=%b od=%h want 0 0 c1",
               br[2], sl[2], od[2]);
    end
    n_vec++;
    if ({ar, br, sl, ov} !== {e_ar, e_br, e_sl, e_ov}) begin
      n_err++;
      $display("FAIL rel_model: ar=%b br=%b sel=%b ov=%b want %b %b %b %b",
               ar, br, sl, ov, e_ar, e_br, e_sl, e_ov);
    end
    tick();
    drive(1'b0, '0, 1'b1, 8'hD1, 1'b1);
    n_vec++;
    if (br[2] !== 1'b1 || sl[2] !== 1'b1) begin
      n_err++;
      $display("FAIL rel_b: br=%b sel=%b want 1 1", br[2], sl[2]);
    end
    tick();
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    n_vec++;
    if (od[2] !== 8'hD1 || ov[2] !== 1'b1) begin
      n_err++;
      $display("FAIL rel_bout: ov=%b od=%h want 1 d1", ov[2], od[2]);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1'b1, 8'h77, 1'b1, 8'h88, 1'b0);
    tick();
    drive(1'b1, 8'h77, 1'b1, 8'h88, 1'b0);
    n_vec++;
    if (ov !== 3'b111) begin
      n_err++;
      $display("FAIL rmid_pre: ov=%b want 111", ov);
    end
    rst_n = 1'b0;
    m_reset();
    #1;
    n_vec++;
    if (ov !== 3'b000 || od[0] !== '0 || od[1] !== '0 || od[2] !== '0) begin
      n_err++;
      $display("FAIL rmid_async: ov=%b od=%h %h %h want 000 00",
               ov, od[0], od[1], od[2]);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 8'h99, 1'b1, 8'hAA, 1'b1);
    n_vec++;
    if (ar !== 3'b111 || br !== 3'b000 || sl !== 3'b000) begin
      n_err++;
      $display("FAIL rmid_prio: ar=%b br=%b sel=%b want 111 000 000",
               ar, br, sl);
    end
    tick();
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (od[i] !== 8'h99) begin
        n_err++;
        $display("FAIL rmid_out[%0d]: od=%h want 99", i, od[i]);
      end
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 9) < 7, W'($urandom),
            $urandom_range(0, 9) < 7, W'($urandom),
            $urandom_range(0, 9) < 7);
      n_vec++;
      if ({ar, br, sl, ov} !== {e_ar, e_br, e_sl, e_ov}) begin
        n_err++;
        $display("FAIL rnd_ctl k=%0d: ar=%b br=%b sel=%b ov=%b want %b %b %b %b",
                 k, ar, br, sl, ov, e_ar, e_br, e_sl, e_ov);
      end
      for (int i = 0; i < 3; i++) begin
        n_vec++;
        if (od[i] !== e_od[i]) begin
          n_err++;
          $display("FAIL rnd_data[%0d] k=%0d: od=%h want %h",
                   i, k, od[i], e_od[i]);
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_a_only();
    test_round_robin();
    test_backpressure();
    test_release();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
